// File: rtl/reg_group_seq.sv
// Instruction sequencer for the 4x8-bit register group: fetches bytes over valid/ready,
// reads operands, runs an 8-bit ALU and writes the result back with one reg_we pulse.
module reg_group_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [1:0] reg_sr,
  output logic [1:0] reg_dr,
  output logic       reg_we,
  output logic [7:0] reg_i,
  input  logic [7:0] reg_s,
  input  logic [7:0] reg_d,
  output logic       flag_z,
  output logic       flag_c,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {IDLE, IMM, EXEC, WB, HALT} state_t;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic       wr;
    logic       upd_z;
    logic       upd_c;
    logic       c;
    logic [7:0] res;
  } alu_t;

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic [7:0] res;
  alu_t       alu_out;

  // A is the destination register (reg_d), B the source (reg_s); 9-bit ops expose carry/borrow.
  function automatic alu_t alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_t       r;
    logic [8:0] t;
    r = '0;
    t = '0;
    case (op)
      OP_MOV: begin r.wr = 1'b1; r.res = b; end
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        r.wr = 1'b1; r.upd_z = 1'b1; r.upd_c = 1'b1; r.c = t[8]; r.res = t[7:0];
      end
      OP_SUB, OP_CMP: begin
        t = {1'b0, a} - {1'b0, b};
        r.wr = (op == OP_SUB); r.upd_z = 1'b1; r.upd_c = 1'b1; r.c = t[8]; r.res = t[7:0];
      end
      OP_AND: begin r.wr = 1'b1; r.upd_z = 1'b1; r.upd_c = 1'b1; r.res = a & b; end
      OP_OR:  begin r.wr = 1'b1; r.upd_z = 1'b1; r.upd_c = 1'b1; r.res = a | b; end
      OP_NOT: begin r.wr = 1'b1; r.upd_z = 1'b1; r.upd_c = 1'b1; r.res = ~b; end
      OP_INC: begin
        t = {1'b0, b} + 9'd1;
        r.wr = 1'b1; r.upd_z = 1'b1; r.upd_c = 1'b1; r.c = t[8]; r.res = t[7:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_out = alu(ir[7:4], reg_d, reg_s);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (instr_valid) begin
        if (instr[7:4] == OP_LDI)       state_nxt = IMM;
        else if (instr[7:4] == OP_HALT) state_nxt = HALT;
        else                            state_nxt = EXEC;
      end
      IMM:     if (instr_valid) state_nxt = WB;
      EXEC:    state_nxt = alu_out.wr ? WB : IDLE;
      WB:      state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) || (state == IMM);
    busy        = (state != IDLE) && (state != HALT);
    halted      = (state == HALT);
    reg_we      = (state == WB) && !rst;
  end

  // IR/RES are reset too so the register-group selects come up as r0 with a zero write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir     <= '0;
      res    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        IMM:  if (instr_valid) res <= instr;
        EXEC: begin
          if (alu_out.wr)    res    <= alu_out.res;
          if (alu_out.upd_z) flag_z <= (alu_out.res == 8'h00);
          if (alu_out.upd_c) flag_c <= alu_out.c;
        end
        default: ;
      endcase
    end
  end

  assign reg_sr = ir[1:0];
  assign reg_dr = ir[3:2];
  assign reg_i  = res;

endmodule

// File: tb/tb_reg_group_seq.sv
// Bench for reg_group_seq: behavioural register group, write scoreboard, vector table
// and hand-written multi-cycle sequences (held valid, HALT, reset in IMM/WB).
module tb_reg_group_seq;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [1:0] reg_sr, reg_dr;
  logic       reg_we;
  logic [7:0] reg_i, reg_s, reg_d;
  logic       flag_z, flag_c, busy, halted;

  reg_group_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .reg_sr(reg_sr), .reg_dr(reg_dr), .reg_we(reg_we), .reg_i(reg_i), .reg_s(reg_s),
    .reg_d(reg_d), .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register group model: combinational reads, write on negedge.
  logic [7:0] rf [4];
  always @(negedge clk) if (reg_we) rf[reg_dr] <= reg_i;
  assign reg_s = rf[reg_sr];
  assign reg_d = rf[reg_dr];

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [1:0] dr; logic [7:0] val; } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (reg_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got dr=%0d val=%02h, required no write", reg_dr, reg_i);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (reg_dr !== e.dr || reg_i !== e.val) begin
          fails++;
          $display("FAIL write: got dr=%0d val=%02h, required dr=%0d val=%02h",
                   reg_dr, reg_i, e.dr, e.val);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the transfer edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    instr = b;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         imm;
    bit         we;
    logic [1:0] dr;
    logic [7:0] val;
    bit         z;
    bit         c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rdy;
    logic [8:0] pat;
    // b0, b1, imm, we, dr, value-of-dr-after, Z, C
    vecs.push_back('{8'h74, 8'h3C, 1, 1, 2'd1, 8'h3C, 0, 0}); // LDI r1,3C
    vecs.push_back('{8'h78, 8'hF0, 1, 1, 2'd2, 8'hF0, 0, 0}); // LDI r2,F0
    vecs.push_back('{8'h74, 8'h20, 1, 1, 2'd1, 8'h20, 0, 0}); // LDI r1,20
    vecs.push_back('{8'h16, 8'h00, 0, 1, 2'd1, 8'h10, 0, 1}); // ADD r1,r2 carry out
    vecs.push_back('{8'h2A, 8'h00, 0, 1, 2'd2, 8'h00, 1, 0}); // SUB r2,r2 zero
    vecs.push_back('{8'h7C, 8'h05, 1, 1, 2'd3, 8'h05, 1, 0}); // LDI r3,05 flags kept
    vecs.push_back('{8'h8D, 8'h00, 0, 0, 2'd3, 8'h05, 0, 1}); // CMP r3,r1 borrow, no write
    vecs.push_back('{8'h37, 8'h00, 0, 1, 2'd1, 8'h00, 1, 0}); // AND r1,r3
    vecs.push_back('{8'h47, 8'h00, 0, 1, 2'd1, 8'h05, 0, 0}); // OR r1,r3
    vecs.push_back('{8'h5B, 8'h00, 0, 1, 2'd2, 8'hFA, 0, 0}); // NOT r2,r3
    vecs.push_back('{8'h02, 8'h00, 0, 1, 2'd0, 8'hFA, 0, 0}); // MOV r0,r2
    vecs.push_back('{8'h7C, 8'hFF, 1, 1, 2'd3, 8'hFF, 0, 0}); // LDI r3,FF
    vecs.push_back('{8'h6F, 8'h00, 0, 1, 2'd3, 8'h00, 1, 1}); // INC r3,r3 wraps
    vecs.push_back('{8'h95, 8'h00, 0, 0, 2'd1, 8'h05, 1, 1}); // NOP, flags kept
    vecs.push_back('{8'h70, 8'h01, 1, 1, 2'd0, 8'h01, 1, 1}); // LDI r0,01
    vecs.push_back('{8'h28, 8'h00, 0, 1, 2'd2, 8'hF9, 0, 0}); // SUB r2,r0 no borrow
    vecs.push_back('{8'h10, 8'h00, 0, 1, 2'd0, 8'h02, 0, 0}); // ADD r0,r0 no carry
    vecs.push_back('{8'h70, 8'h01, 1, 1, 2'd0, 8'h01, 0, 0}); // LDI r0,01

    rst = 1'b1; instr_valid = 1'b0; instr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(reg_we), 32'd0);
    rst = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_flags", 32'({flag_z, flag_c}), 32'd0);
    chk("rst_sel", 32'({reg_sr, reg_dr}), 32'd0);
    chk("rst_i", 32'(reg_i), 32'd0);

    foreach (vecs[k]) begin
      if (vecs[k].we) exp_q.push_back('{vecs[k].dr, vecs[k].val});
      send(vecs[k].b0);
      if (vecs[k].imm) send(vecs[k].b1);
      wait_idle();
      chk($sformatf("v%0d_reg", k), 32'(rf[vecs[k].dr]), 32'(vecs[k].val));
      chk($sformatf("v%0d_z", k), 32'(flag_z), 32'(vecs[k].z));
      chk($sformatf("v%0d_c", k), 32'(flag_c), 32'(vecs[k].c));
      chk($sformatf("v%0d_pending", k), 32'(exp_q.size()), 32'd0);
    end

    // INC r0 x3 with valid held high: ready once every three cycles.
    exp_q.push_back('{2'd0, 8'h02});
    exp_q.push_back('{2'd0, 8'h03});
    exp_q.push_back('{2'd0, 8'h04});
    instr = 8'h60; instr_valid = 1'b1;
    rdy = 0; pat = '0;
    for (int i = 0; i < 9; i++) begin
      pat[i] = instr_ready;
      if (instr_ready) rdy++;
      @(posedge clk); #1;
      if (rdy == 3) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    chk("inc3_ready_pattern", 32'(pat), 32'h049);
    chk("inc3_r0", 32'(rf[0]), 32'h04);
    chk("inc3_flags", 32'({flag_z, flag_c}), 32'd0);

    // Set r3 and Z, then reset during WB of OR r1,r1: write dropped, flags cleared.
    exp_q.push_back('{2'd3, 8'hFF});
    send(8'h7C); send(8'hFF); wait_idle();
    exp_q.push_back('{2'd2, 8'h00});
    send(8'h2A); wait_idle();
    chk("sub_z", 32'(flag_z), 32'd1);
    send(8'h45);
    @(posedge clk); #1;
    chk("wb_state", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("wb_rst_r1", 32'(rf[1]), 32'h05);
    chk("wb_rst_flags", 32'({flag_z, flag_c}), 32'd0);
    chk("wb_rst_busy", 32'(busy), 32'd0);

    // HALT holds off all input until reset.
    send(8'hF0);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    instr = 8'h74; instr_valid = 1'b1;
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready || !halted) rdy++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("halt_hold", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("halt_exit", 32'({halted, instr_ready}), 32'b01);

    // Reset inside IMM: the LDI is abandoned and 3Ch decodes as AND r3,r0.
    send(8'h74);
    chk("imm_state", 32'({busy, instr_ready}), 32'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back('{2'd3, 8'h04});
    send(8'h3C); wait_idle();
    chk("imm_rst_r1", 32'(rf[1]), 32'h05);
    chk("imm_rst_r3", 32'(rf[3]), 32'h04);
    chk("imm_rst_flags", 32'({flag_z, flag_c}), 32'd0);

    repeat (2) @(posedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_group_seq.md
# reg_group_seq

Instruction sequencer for the 4×8-bit register group (`reg_group`: 2-bit `sr`/`dr` selects, `we`, 8-bit `i` in, `s`/`d` out, write on negedge `clk`).
- Accepts 8-bit instructions over a valid/ready handshake.
- Reads operands from the register group, computes an 8-bit result with an internal ALU, and writes it back through a single write-enable pulse.
- Maintains zero/carry flags and a halt state.
- Sits between the instruction source (fetch unit or testbench) and the register group.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk` in 1: system clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: `instr` holds a valid byte.
- `instr` in 8: instruction or immediate byte; `[7:4]` opcode, `[3:2]` dr, `[1:0]` sr.
- `instr_ready` out 1: sequencer accepts a byte this cycle.
- `reg_sr` out 2: to `reg_group.sr`.
- `reg_dr` out 2: to `reg_group.dr`.
- `reg_we` out 1: to `reg_group.we`.
- `reg_i` out 8: to `reg_group.i`.
- `reg_s` in 8: from `reg_group.s`.
- `reg_d` in 8: from `reg_group.d`.
- `flag_z` out 1: zero flag.
- `flag_c` out 1: carry/borrow flag.
- `busy` out 1: state is not IDLE or HALT.
- `halted` out 1: HALT executed.

## Operation
States:
- IDLE: `instr_ready`=1. Transfer (valid & ready at posedge) latches `instr` into IR.
  - LDI → IMM.
  - HALT → HALT.
  - any other opcode → EXEC.
- IMM: `instr_ready`=1. Transfer latches the byte into RES → WB.
- EXEC: one cycle. ALU computes from `reg_d` (A) and `reg_s` (B); result latches into RES and flags update at the end of the cycle.
  - Writing ops → WB.
  - CMP and NOP → IDLE.
- WB: `reg_we`=1 for exactly this cycle with `reg_i`=RES → IDLE.
- HALT: `instr_ready`=0, `halted`=1. Only `rst` exits.

Output drive:
- `reg_sr` = IR[1:0] and `reg_dr` = IR[3:2` at all times.
- `reg_i` = RES.
- `reg_we` = (state==WB) & !rst, so no register write occurs while `rst` is high.

Opcodes (all arithmetic mod 256):
- 0h MOV: dr←B. Flags unchanged.
- 1h ADD: dr←A+B. C = bit 8 of the 9-bit sum.
- 2h SUB: dr←A−B. C=1 iff A<B (borrow).
- 3h AND, 4h OR: dr←A op B. C←0.
- 5h NOT: dr←~B. C←0.
- 6h INC: dr←B+1. C=1 iff B=FFh.
- 7h LDI: dr←next byte. sr ignored. Flags unchanged.
- 8h CMP: flags from A−B as for SUB. No write.
- Fh HALT.
- 9h–Eh NOP: no write, flags unchanged, EXEC → IDLE.

Flags:
- Z = (result==0) for ADD/SUB/AND/OR/NOT/INC/CMP.
- Z unchanged for MOV/LDI/NOP.
- dr==sr is legal; both operands read the same register.

## Timing
- Reset values:
  - state IDLE, IR=00h, RES=00h.
  - `flag_z`=0, `flag_c`=0, `halted`=0, `busy`=0.
  - `reg_we`=0, `reg_sr`=`reg_dr`=00, `reg_i`=00h, `instr_ready`=1 (after the reset edge).
- ALU/logic/MOV/INC: transfer at edge k.
  - EXEC occupies cycle k..k+1.
  - WB occupies cycle k+1..k+2; the register is written at the negedge inside WB.
  - `instr_ready` returns high in the cycle after edge k+2. Throughput is one instruction per 3 cycles.
- CMP/NOP: 2 cycles; no `reg_we`.
- LDI: first byte at edge k, immediate byte at edge ≥k+1 (IMM waits indefinitely for valid), WB in the following cycle.
- Dependent back-to-back instructions need no stall: the negedge write in WB precedes the next EXEC.
- `instr_valid` is ignored outside IDLE/IMM. A byte not handshaken is not consumed.
- `rst` mid-IMM/EXEC/WB:
  - pending write abandoned;
  - flags cleared;
  - next accepted byte decoded as an opcode.
- Register group contents are not reset by this block.

## Test plan
- Reset, then LDI r1,3Ch (bytes 74h, 3Ch) → exactly one `reg_we` cycle with `reg_dr`=01, `reg_i`=3Ch; r1=3Ch; flags 0/0.
- LDI r2,F0h; LDI r1,20h; ADD r1,r2 (16h) → r1=10h, C=1, Z=0. Then SUB r2,r2 (2Ah) → r2=00h, Z=1, C=0.
- LDI r3,05h; CMP r3,r1 with r1=10h (8Dh) → no `reg_we` asserted, C=1, Z=0, r3 still 05h.
- `instr_valid` held high with INC r0 ×3 (60h, 60h, 60h) and r0=01h → `instr_ready` high 1 of every 3 cycles, r0=04h after third WB.
- HALT (F0h) → `halted`=1, `instr_ready`=0 for ≥20 cycles despite valid; `rst` for one cycle → IDLE, `halted`=0.
- LDI first byte 74h, then `rst` in IMM, then byte 3Ch → no write to r1; 3Ch is decoded as AND r3,r0.
